// File: rtl/overdrive_staged.sv
// overdrive_staged: three-stage gain / saturate / limit pipeline with valid-ready
// handshake, selectable hard-clip or soft-knee limiting and a saturating clip counter.
`default_nettype none

module overdrive_staged #(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 4,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [GAIN_W-1:0] gain,
  input  logic        [DATA_W-2:0] thr,
  input  logic        [1:0]        mode,
  input  logic                     clr_cnt,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_clip,
  output logic        [CNT_W-1:0]  clip_cnt
);

  localparam int PROD_W = DATA_W + GAIN_W;
  localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [1:0] MODE_CLIP = 2'b01;
  localparam logic [1:0] MODE_KNEE = 2'b10;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // S1: full-precision product; thr and mode ride along with the sample
  logic                     s1_valid;
  logic signed [PROD_W-1:0] s1_prod;
  logic        [DATA_W-2:0] s1_thr;
  logic        [1:0]        s1_mode;
  logic signed [PROD_W-1:0] prod;

  assign prod = PROD_W'(in_data) * PROD_W'(gain);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_thr   <= '0;
      s1_mode  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_prod <= prod;
        s1_thr  <= thr;
        s1_mode <= mode;
      end
    end
  end

  // S2: floor-scale by the gain's fractional bits, then saturate to DATA_W
  logic                     s2_valid;
  logic signed [DATA_W-1:0] s2_x;
  logic                     s2_sat;
  logic        [DATA_W-2:0] s2_thr;
  logic        [1:0]        s2_mode;
  logic signed [PROD_W-1:0] scaled;
  logic signed [DATA_W-1:0] sat_val;
  logic                     sat_hit;

  assign scaled = s1_prod >>> GAIN_FRAC;

  always_comb begin
    sat_val = scaled[DATA_W-1:0];
    sat_hit = 1'b0;
    if (scaled > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
      sat_hit = 1'b1;
    end else if (scaled < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_x     <= '0;
      s2_sat   <= 1'b0;
      s2_thr   <= '0;
      s2_mode  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_x    <= sat_val;
        s2_sat  <= sat_hit;
        s2_thr  <= s1_thr;
        s2_mode <= s1_mode;
      end
    end
  end

  // S3: limiter; thr never exceeds the positive range so -thr is representable
  logic signed [DATA_W-1:0] thr_s;
  logic signed [DATA_W-1:0] neg_thr;
  logic signed [DATA_W-1:0] lim;
  logic                     lim_hit;

  assign thr_s   = {1'b0, s2_thr};
  assign neg_thr = -thr_s;

  always_comb begin
    lim     = s2_x;
    lim_hit = 1'b0;
    case (s2_mode)
      MODE_CLIP: begin
        if (s2_x > thr_s) begin
          lim     = thr_s;
          lim_hit = 1'b1;
        end else if (s2_x < neg_thr) begin
          lim     = neg_thr;
          lim_hit = 1'b1;
        end
      end
      MODE_KNEE: begin
        if (s2_x > thr_s) begin
          lim     = thr_s + ((s2_x - thr_s) >>> 1);
          lim_hit = 1'b1;
        end else if (s2_x < neg_thr) begin
          lim     = neg_thr + ((s2_x + thr_s) >>> 1);
          lim_hit = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_clip  <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= lim;
        out_clip <= s2_sat || lim_hit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_cnt <= '0;
    end else if (clr_cnt) begin
      clip_cnt <= '0;
    end else if (out_valid && out_ready && out_clip && (clip_cnt != {CNT_W{1'b1}})) begin
      clip_cnt <= clip_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_overdrive_staged.sv
// tb_overdrive_staged: directed and randomized checks of overdrive_staged against
// an integer reference model and an expected-output queue.
`timescale 1ns/1ps
`default_nettype none

module tb_overdrive_staged;

  localparam int DW = 16;
  localparam int GW = 16;
  localparam int GF = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [GW-1:0] gain;
  logic        [DW-2:0] thr;
  logic        [1:0]    mode;
  logic                 clr_cnt;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_clip;
  logic        [15:0]   clip_cnt;
  logic                 in_ready4;
  logic signed [DW-1:0] out_data4;
  logic                 out_valid4;
  logic                 out_clip4;
  logic        [3:0]    clip_cnt4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  overdrive_staged #(.DATA_W(DW), .GAIN_W(GW), .GAIN_FRAC(GF), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .gain(gain), .thr(thr), .mode(mode), .clr_cnt(clr_cnt), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_clip(out_clip), .clip_cnt(clip_cnt)
  );

  overdrive_staged #(.DATA_W(DW), .GAIN_W(GW), .GAIN_FRAC(GF), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
    .gain(gain), .thr(thr), .mode(mode), .clr_cnt(clr_cnt), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_clip(out_clip4), .clip_cnt(clip_cnt4)
  );

  // Reference: real-valued gain, floor to integer, clamp to range, then limiter rule.
  function automatic void model(input int d, input int g, input int t, input int m,
                                output int y, output bit c);
    longint p;
    longint s;
    int     x;
    bit     sat;
    p   = longint'(d) * longint'(g);
    s   = (p >= 0) ? (p / 16) : -((-p + 15) / 16);
    sat = 1'b0;
    if (s > 32767) begin x = 32767; sat = 1'b1; end
    else if (s < -32768) begin x = -32768; sat = 1'b1; end
    else x = int'(s);
    y = x;
    c = sat;
    if (m == 1) begin
      if (x > t) begin y = t; c = 1'b1; end
      else if (x < -t) begin y = -t; c = 1'b1; end
    end else if (m == 2) begin
      if (x > t) begin y = t + (x - t) / 2; c = 1'b1; end
      else if (x < -t) begin y = -t - ((-(x + t) + 1) / 2); c = 1'b1; end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input int g, input int t, input int m);
    in_data = 16'(d);
    gain    = 16'(g);
    thr     = 15'(t);
    mode    = 2'(m);
  endtask

  task automatic rand_in();
    in_data = 16'($urandom);
    gain    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 80)) - 16'd40;
    thr     = 15'($urandom_range(0, 8000));
    mode    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (out_data !== 16'sd0) begin fails++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    tests++; if (out_clip !== 1'b0) begin fails++; $display("FAIL reset_out_clip: got %b expected 0", out_clip); end
    tests++; if (clip_cnt !== 16'd0) begin fails++; $display("FAIL reset_clip_cnt: got %0d expected 0", clip_cnt); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unity();
    int n;
    out_ready = 1'b1;
    set_in(1000, 16, 4096, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    tests++; if (n + 1 != 3) begin fails++; $display("FAIL unity_latency: got %0d expected 3", n + 1); end
    tests++; if (out_data !== 16'sd1000) begin fails++; $display("FAIL unity_data: got %0d expected 1000", out_data); end
    tests++; if (out_clip !== 1'b0) begin fails++; $display("FAIL unity_clip: got %b expected 0", out_clip); end
    tick();
  endtask

  task automatic test_hard_clip();
    int n;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    set_in(1000, 256, 4096, 1);
    in_valid = 1'b1;
    tick();
    in_data = -16'sd1000;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    tests++; if (out_data !== 16'sd4096 || out_clip !== 1'b1) begin fails++; $display("FAIL hardclip_pos: got %0d/%b expected 4096/1", out_data, out_clip); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== -16'sd4096 || out_clip !== 1'b1) begin fails++; $display("FAIL hardclip_neg: got %0d/%b expected -4096/1", out_data, out_clip); end
    tick();
    tests++; if (clip_cnt !== 16'd2) begin fails++; $display("FAIL hardclip_cnt: got %0d expected 2", clip_cnt); end
  endtask

  task automatic test_knee_and_sat();
    int n;
    set_in(1000, 96, 4096, 2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    tests++; if (out_data !== 16'sd5048 || out_clip !== 1'b1) begin fails++; $display("FAIL knee: got %0d/%b expected 5048/1", out_data, out_clip); end
    tick();
    set_in(32767, 32767, 4096, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    tests++; if (out_data !== 16'sd32767 || out_clip !== 1'b1) begin fails++; $display("FAIL sat_pos: got %0d/%b expected 32767/1", out_data, out_clip); end
    tick();
    set_in(-32768, 32767, 100, 3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    tests++; if (out_data !== -16'sd32768 || out_clip !== 1'b1) begin fails++; $display("FAIL sat_neg: got %0d/%b expected -32768/1", out_data, out_clip); end
    tick();
  endtask

  // Streams n samples; fixed stall window [slo,shi) or random handshakes when rnd=1.
  task automatic test_stream(input int n, input int slo, input int shi, input bit rnd);
    int exp_d[$];
    bit exp_c[$];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int y;
    int ed;
    bit c;
    bit ec;
    bit prev_stall = 1'b0;
    logic signed [DW-1:0] prev_d = '0;
    logic prev_c = 1'b0;
    out_ready = 1'b1;
    rand_in();
    in_valid = 1'b1;
    while (got < n && cyc < n * 10 + 50) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got++;
        tests++;
        if (exp_d.size() == 0) begin
          fails++; $display("FAIL stream_extra: got %0d with no sample expected", out_data);
        end else begin
          ed = exp_d.pop_front();
          ec = exp_c.pop_front();
          if (out_data !== 16'(ed) || out_clip !== ec) begin
            fails++; $display("FAIL stream_data: got %0d/%b expected %0d/%b", out_data, out_clip, ed, ec);
          end
        end
      end
      if (out_valid && !out_ready) begin
        if (prev_stall) begin
          tests++;
          if (out_data !== prev_d || out_clip !== prev_c) begin
            fails++; $display("FAIL stall_hold: got %0d/%b expected %0d/%b", out_data, out_clip, prev_d, prev_c);
          end
        end
        prev_stall = 1'b1;
        prev_d = out_data;
        prev_c = out_clip;
      end else begin
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready) begin
        model(int'(in_data), int'(gain), int'(thr), int'(mode), y, c);
        exp_d.push_back(y);
        exp_c.push_back(c);
        sent++;
      end
      tick();
      cyc++;
      rand_in();
      in_valid  = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= slo && cyc < shi);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++; if (got != n || exp_d.size() != 0) begin fails++; $display("FAIL stream_count: got %0d left %0d expected %0d left 0", got, exp_d.size(), n); end
    tick();
  endtask

  task automatic test_reset_flight();
    int pulses = 0;
    int first = -1;
    logic signed [DW-1:0] seen = '0;
    out_ready = 1'b1;
    set_in(1000, 256, 100, 1);
    in_valid = 1'b1;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flight_rst_valid: got %b expected 0", out_valid); end
    tests++; if (clip_cnt !== 16'd0) begin fails++; $display("FAIL flight_rst_cnt: got %0d expected 0", clip_cnt); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    set_in(500, 16, 4096, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (out_valid) begin
        pulses++;
        if (first < 0) begin first = k; seen = out_data; end
      end
      tick();
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL flight_pulses: got %0d expected 1", pulses); end
    tests++; if (first != 3 || seen !== 16'sd500) begin fails++; $display("FAIL flight_sample: got %0d at %0d expected 500 at 3", seen, first); end
  endtask

  task automatic test_counter_sat();
    int n;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    tests++; if (clip_cnt4 !== 4'd0) begin fails++; $display("FAIL cnt_clear: got %0d expected 0", clip_cnt4); end
    out_ready = 1'b1;
    set_in(100, 16, 0, 1);
    in_valid = 1'b1;
    repeat (20) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    tests++; if (clip_cnt4 !== 4'd15) begin fails++; $display("FAIL cnt_sat4: got %0d expected 15", clip_cnt4); end
    tests++; if (clip_cnt !== 16'd20) begin fails++; $display("FAIL cnt_wide: got %0d expected 20", clip_cnt); end
    set_in(-100, 16, 0, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    tests++; if (out_data !== 16'sd0 || out_clip !== 1'b1) begin fails++; $display("FAIL thr0_clip: got %0d/%b expected 0/1", out_data, out_clip); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    tests++; if (clip_cnt4 !== 4'd0 || clip_cnt !== 16'd0) begin fails++; $display("FAIL cnt_clr_priority: got %0d/%0d expected 0/0", clip_cnt4, clip_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    gain      = '0;
    thr       = '0;
    mode      = '0;
    clr_cnt   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_unity();
    test_hard_clip();
    test_knee_and_sat();
    test_stream(8, 5, 9, 1'b0);
    test_stream(300, 0, 0, 1'b1);
    test_reset_flight();
    test_counter_sat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
